// File: rtl/adding_ctrl_pkg.sv
// Shared types and constants for the accumulator-machine controller:
// state encoding, opcode field values and the HALT instruction encoding.
package adding_ctrl_pkg;

  typedef enum logic [2:0] {
    S_CLR,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [7:0] HALT_INSTR = 8'hFF;

  // Opcode field of an instruction word.
  function automatic logic [1:0] opcode_of(input logic [7:0] ir);
    return ir[7:6];
  endfunction

endpackage

// File: rtl/adding_ctrl_wait_timer.sv
// Memory wait timer: counts cycles a memory access has been stalled and
// flags expiry combinationally in the cycle that would reach WAIT_MAX.
module adding_ctrl_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over counting a stalled cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The stalled cycle that would bring the count to WAIT_MAX is the expiring one.
  assign expired_o = enable_i && (cnt_q == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/adding_controller.sv
// Control FSM for a 4-instruction accumulator machine (LDA/ADD/STA/JMP).
// Memory-ready-dependent strobes are Mealy; everything else is decoded from
// state. A stalled memory access beyond WAIT_MAX cycles sets a sticky bus
// error and halts until reset.
// Optional build macro ADDING_CTRL_HALT_EN: instruction 8'hFF halts the
// machine in DECODE instead of executing as JMP 63.
module adding_controller
  import adding_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ir_in,
  input  logic       mem_ready,
  output logic       load_IR,
  output logic       load_acc,
  output logic       ld_pc,
  output logic       clr_pc,
  output logic       inc_pc,
  output logic       sel_alu,
  output logic       sel_bus,
  output logic       pass_add,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic       busy,
  output logic       halted,
  output logic       bus_err
);

  state_e     state_q;
  state_e     state_d;
  logic       bus_err_q;
  logic       bus_err_d;
  logic       wait_clear;
  logic       wait_enable;
  logic       wait_expired;
  logic       halt_hit;
  logic [1:0] opcode;

  assign opcode = opcode_of(ir_in);

`ifdef ADDING_CTRL_HALT_EN
  assign halt_hit = (ir_in == HALT_INSTR);
`else
  // Operand bits are datapath-only when the halt decode is not built.
  logic unused_operand;
  assign unused_operand = ^ir_in[5:0];
  assign halt_hit       = 1'b0;
`endif

  adding_ctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (wait_clear),
    .enable_i  (wait_enable),
    .expired_o (wait_expired)
  );

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    load_IR   = 1'b0;
    load_acc  = 1'b0;
    ld_pc     = 1'b0;
    clr_pc    = 1'b0;
    inc_pc    = 1'b0;
    sel_alu   = 1'b0;
    sel_bus   = 1'b0;
    pass_add  = 1'b0;
    ir_on_adr = 1'b0;
    pc_on_adr = 1'b0;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;

    unique case (state_q)
      S_CLR: begin
        clr_pc  = 1'b1;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        busy      = 1'b1;
        pc_on_adr = 1'b1;
        rd_mem    = 1'b1;
        if (mem_ready) begin
          load_IR = 1'b1;
          inc_pc  = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_HALT;
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        if (halt_hit) begin
          state_d = S_HALT;
        end else if (opcode == OP_JMP) begin
          ld_pc   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        busy      = 1'b1;
        ir_on_adr = 1'b1;
        if (opcode == OP_STA) begin
          wr_mem = 1'b1;
        end else begin
          rd_mem = 1'b1;
        end
        if (mem_ready) begin
          if (opcode == OP_LDA) begin
            sel_bus  = 1'b1;
            load_acc = 1'b1;
          end else if (opcode == OP_ADD) begin
            sel_alu  = 1'b1;
            pass_add = 1'b1;
            load_acc = 1'b1;
          end
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d = S_HALT;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_CLR;
      end
    endcase
  end

  // Wait timer control: restart on entry to a memory state, count stalls in one.
  assign wait_clear  = (state_d != state_q) &&
                       ((state_d == S_FETCH) || (state_d == S_EXEC));
  assign wait_enable = ((state_q == S_FETCH) || (state_q == S_EXEC)) && !mem_ready;

  // Bus error is sticky until reset.
  assign bus_err_d = bus_err_q | wait_expired;
  assign bus_err   = bus_err_q;

  // State and status registers; reset forces S_CLR mid-instruction too.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLR;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_adding_controller.sv
// Directed-vector bench for adding_controller. All outputs are packed into one
// vector and compared per cycle against hand-derived expectations.
module tb_adding_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ir_in;
  logic       mem_ready;
  logic       load_IR, load_acc, ld_pc, clr_pc, inc_pc;
  logic       sel_alu, sel_bus, pass_add, ir_on_adr, pc_on_adr;
  logic       rd_mem, wr_mem, busy, halted, bus_err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [14:0] B_LIR  = 15'h4000;
  localparam logic [14:0] B_LACC = 15'h2000;
  localparam logic [14:0] B_LDPC = 15'h1000;
  localparam logic [14:0] B_CLR  = 15'h0800;
  localparam logic [14:0] B_INC  = 15'h0400;
  localparam logic [14:0] B_SALU = 15'h0200;
  localparam logic [14:0] B_SBUS = 15'h0100;
  localparam logic [14:0] B_PADD = 15'h0080;
  localparam logic [14:0] B_IRA  = 15'h0040;
  localparam logic [14:0] B_PCA  = 15'h0020;
  localparam logic [14:0] B_RD   = 15'h0010;
  localparam logic [14:0] B_WR   = 15'h0008;
  localparam logic [14:0] B_BUSY = 15'h0004;
  localparam logic [14:0] B_HLT  = 15'h0002;
  localparam logic [14:0] B_BERR = 15'h0001;

  localparam logic [14:0] E_FETCH_RDY  = B_PCA | B_RD | B_BUSY | B_LIR | B_INC;
  localparam logic [14:0] E_FETCH_WAIT = B_PCA | B_RD | B_BUSY;

  logic [14:0] outs;
  assign outs = {load_IR, load_acc, ld_pc, clr_pc, inc_pc, sel_alu, sel_bus,
                 pass_add, ir_on_adr, pc_on_adr, rd_mem, wr_mem, busy, halted, bus_err};

  adding_controller #(.WAIT_MAX(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .ir_in     (ir_in),
    .mem_ready (mem_ready),
    .load_IR   (load_IR),
    .load_acc  (load_acc),
    .ld_pc     (ld_pc),
    .clr_pc    (clr_pc),
    .inc_pc    (inc_pc),
    .sel_alu   (sel_alu),
    .sel_bus   (sel_bus),
    .pass_add  (pass_add),
    .ir_on_adr (ir_on_adr),
    .pc_on_adr (pc_on_adr),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .busy      (busy),
    .halted    (halted),
    .bus_err   (bus_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; ir_in = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (outs !== B_CLR) begin
      n_err++; $display("FAIL reset_held: got %b want %b", outs, B_CLR);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (outs !== B_CLR) begin
      n_err++; $display("FAIL reset_first_cycle: got %b want %b", outs, B_CLR);
    end
    tick();
  endtask

  task automatic test_fetch();
    ir_in = 8'h05; mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (outs !== E_FETCH_RDY) begin
      n_err++; $display("FAIL fetch_ready: got %b want %b", outs, E_FETCH_RDY);
    end
    tick();
  endtask

  // Starts in DECODE of LDA 5; ready in DECODE must be ignored.
  task automatic test_lda();
    logic [14:0] ev [4];
    logic        rv [4];
    ev = '{B_BUSY, B_IRA | B_RD | B_BUSY, B_IRA | B_RD | B_BUSY,
           B_IRA | B_RD | B_BUSY | B_LACC | B_SBUS};
    rv = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      mem_ready = rv[i];
      #1;
      n_cmp++;
      if (outs !== ev[i]) begin
        n_err++; $display("FAIL lda step %0d: got %b want %b", i, outs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_add();
    logic [14:0] ev [3];
    logic        rv [3];
    ir_in = 8'h43;
    ev = '{E_FETCH_RDY, B_BUSY, B_IRA | B_RD | B_BUSY | B_LACC | B_SALU | B_PADD};
    rv = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      mem_ready = rv[i];
      #1;
      n_cmp++;
      if (outs !== ev[i]) begin
        n_err++; $display("FAIL add step %0d: got %b want %b", i, outs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_sta();
    logic [14:0] ev [4];
    logic        rv [4];
    ir_in = 8'h8A;
    ev = '{E_FETCH_RDY, B_BUSY, B_IRA | B_WR | B_BUSY, B_IRA | B_WR | B_BUSY};
    rv = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      mem_ready = rv[i];
      #1;
      n_cmp++;
      if (outs !== ev[i]) begin
        n_err++; $display("FAIL sta step %0d: got %b want %b", i, outs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_jmp();
    logic [14:0] ev [2];
    logic        rv [2];
    ir_in = 8'hC9;
    ev = '{E_FETCH_RDY, B_BUSY | B_LDPC};
    rv = '{1'b1, 1'b1};
    for (int i = 0; i < 2; i++) begin
      mem_ready = rv[i];
      #1;
      n_cmp++;
      if (outs !== ev[i]) begin
        n_err++; $display("FAIL jmp step %0d: got %b want %b", i, outs, ev[i]);
      end
      tick();
    end
  endtask

  // 8'hFF: halts in the macro build, otherwise behaves as JMP 63.
  task automatic test_halt_instr();
    logic [14:0] ev [3];
    logic        rv [3];
    ir_in = 8'hFF;
`ifdef ADDING_CTRL_HALT_EN
    ev = '{E_FETCH_RDY, B_BUSY, B_HLT};
`else
    ev = '{E_FETCH_RDY, B_BUSY | B_LDPC, E_FETCH_WAIT};
`endif
    rv = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      mem_ready = rv[i];
      #1;
      n_cmp++;
      if (outs !== ev[i]) begin
        n_err++; $display("FAIL halt_instr step %0d: got %b want %b", i, outs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    reset = 1'b1; mem_ready = 1'b0; ir_in = 8'h05;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      #1;
      n_cmp++;
      if (outs !== E_FETCH_WAIT) begin
        n_err++; $display("FAIL timeout_wait cycle %0d: got %b want %b", i, outs, E_FETCH_WAIT);
      end
      tick();
    end
    n_cmp++;
    if (outs !== (B_HLT | B_BERR)) begin
      n_err++; $display("FAIL timeout_halt: got %b want %b", outs, B_HLT | B_BERR);
    end
    mem_ready = 1'b1;
    tick();
    n_cmp++;
    if (outs !== (B_HLT | B_BERR)) begin
      n_err++; $display("FAIL halt_ignores_ready: got %b want %b", outs, B_HLT | B_BERR);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== B_CLR) begin
      n_err++; $display("FAIL timeout_reset_clears: got %b want %b", outs, B_CLR);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Reset asserted while an LDA is waiting in EXEC.
  task automatic test_mid_reset();
    ir_in = 8'h05; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (outs !== (B_IRA | B_RD | B_BUSY)) begin
      n_err++; $display("FAIL mid_reset_exec: got %b want %b", outs, B_IRA | B_RD | B_BUSY);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== B_CLR) begin
      n_err++; $display("FAIL mid_reset_async: got %b want %b", outs, B_CLR);
    end
    tick();
    reset = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (outs !== E_FETCH_WAIT) begin
      n_err++; $display("FAIL mid_reset_refetch: got %b want %b", outs, E_FETCH_WAIT);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_lda();
    test_add();
    test_sta();
    test_jmp();
    test_halt_instr();
    test_timeout();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
